// File: rtl/l2k_ram_resp.sv
// l2k_ram_resp: word-addressed on-chip RAM behind the Limn2600 external bus.
// A request is captured from addr/wdata/we when ce is seen high in IDLE. After
// WAIT_STATES further edges the block presents a single-cycle rdy, plus err
// when the captured address is misaligned or outside the RAM window.
//
// Handshake: the initiator raises ce with addr/wdata/we valid and must hold ce
// high until rdy; dropping ce while waiting abandons the request (no rdy, no
// write). rdy is high for exactly one cycle, err only ever accompanies rdy, and
// ce is ignored during that rdy cycle. A ce still high in the following IDLE
// cycle is taken as a fresh request.
module l2k_ram_resp #(
   parameter int          DEPTH_LOG2  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        we,
   input  logic        ce,
   output logic        rdy,
   output logic        err
);

   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_WAIT = 2'd1;
   localparam logic [1:0]  S_RESP = 2'd2;

   localparam logic [32:0] WINDOW_BYTES = 33'd4 << DEPTH_LOG2;
   localparam logic [3:0]  WS_INIT      = 4'(WAIT_STATES);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;

   logic [31:0] mem [2**DEPTH_LOG2];

   logic [31:0] req_addr;
   logic        req_we;
   logic        enter_resp;
   logic        bad_q;

   // The offset is taken 33 bits wide so an address below BASE_ADDR wraps to
   // a huge value and fails the same upper-bound test as one above the window.
   function automatic logic out_of_window(input logic [31:0] a);
      logic [32:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a[1:0] != 2'b00) || (off >= WINDOW_BYTES);
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] a);
      return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
   endfunction

   // With zero wait states the response is entered on the capture edge itself,
   // so the request must come straight from the bus rather than the registers.
   always_comb begin
      req_addr   = (state == S_IDLE) ? addr : addr_q;
      req_we     = (state == S_IDLE) ? we   : we_q;
      enter_resp = ((state == S_IDLE) && ce && (WAIT_STATES == 0)) ||
                   ((state == S_WAIT) && ce && (cnt == 4'd1));
      bad_q      = out_of_window(addr_q);
      rdy        = (state == S_RESP);
      err        = (state == S_RESP) && bad_q;
   end

   // Request FSM: capture in IDLE, count wait states, one RESP cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ce) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  we_q    <= we;
                  if (WAIT_STATES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= WS_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (!ce) begin
                  state <= S_IDLE;
                  cnt   <= 4'd0;
               end else if (cnt == 4'd1) begin
                  state <= S_RESP;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Read data is loaded on entry to RESP and held until the next read response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= 32'd0;
      end else if (enter_resp && !req_we) begin
         rdata <= out_of_window(req_addr) ? 32'd0 : mem[word_index(req_addr)];
      end
   end

   // Writes commit on the RESP->IDLE edge; a reset before then discards them.
   always_ff @(posedge clk) begin
      if ((state == S_RESP) && we_q && !bad_q) begin
         mem[word_index(addr_q)] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_l2k_ram_resp.sv
// tb_l2k_ram_resp: three responders with different wait-state counts and
// windows, driven one request at a time, checked by a scoreboard monitor.
module tb_l2k_ram_resp;

   logic        clk;
   logic        rst;
   logic [31:0] addr_v  [3];
   logic [31:0] wdata_v [3];
   logic [2:0]  we_v;
   logic [2:0]  ce_v;
   logic [31:0] rdata0, rdata1, rdata2;
   logic        rdy0, rdy1, rdy2;
   logic        err0, err1, err2;
   logic [2:0]  rdy_v;
   logic [2:0]  err_v;

   assign rdy_v = {rdy2, rdy1, rdy0};
   assign err_v = {err2, err1, err0};

   int tests_run    = 0;
   int tests_failed = 0;

   // {dut index, err, rdata}
   logic [34:0] exp_q [$];
   logic [34:0] mon_e;

   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] last_rd [3];

   l2k_ram_resp #(.DEPTH_LOG2(6), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)) u_dut0 (
      .clk(clk), .rst(rst), .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata0),
      .we(we_v[0]), .ce(ce_v[0]), .rdy(rdy0), .err(err0));

   l2k_ram_resp #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0100), .WAIT_STATES(0)) u_dut1 (
      .clk(clk), .rst(rst), .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata1),
      .we(we_v[1]), .ce(ce_v[1]), .rdy(rdy1), .err(err1));

   l2k_ram_resp #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0200), .WAIT_STATES(1)) u_dut2 (
      .clk(clk), .rst(rst), .addr(addr_v[2]), .wdata(wdata_v[2]), .rdata(rdata2),
      .we(we_v[2]), .ce(ce_v[2]), .rdy(rdy2), .err(err2));

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic longint base_of(input int k);
      case (k)
         0: return 64'h000;
         1: return 64'h100;
         default: return 64'h200;
      endcase
   endfunction

   function automatic longint words_of(input int k);
      return (k == 0) ? 64 : 16;
   endfunction

   function automatic int ws_of(input int k);
      case (k)
         0: return 2;
         1: return 0;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] rdata_of(input int k);
      case (k)
         0: return rdata0;
         1: return rdata1;
         default: return rdata2;
      endcase
   endfunction

   function automatic bit model_bad(input int k, input logic [31:0] a);
      longint x;
      x = longint'(a);
      return (x % 4 != 0) || (x < base_of(k)) || (x >= base_of(k) + 4 * words_of(k));
   endfunction

   // Reference model: apply the request to the memory image, queue the response.
   task automatic push_exp(input int k, input logic [31:0] a, input bit w, input logic [31:0] d);
      bit          bad;
      logic [31:0] e;
      bad = model_bad(k, a);
      if (!w) begin
         e = (bad || !mem_m.exists(a)) ? 32'd0 : mem_m[a];
         last_rd[k] = e;
      end else begin
         e = last_rd[k];
         if (!bad) mem_m[a] = d;
      end
      exp_q.push_back({2'(k), bad, e});
   endtask

   // Full request; inputs are scrambled after capture to prove they are ignored.
   task automatic req(input int k, input logic [31:0] a, input bit w, input logic [31:0] d, input bit keep);
      int lat;
      addr_v[k] = a; wdata_v[k] = d; we_v[k] = w; ce_v[k] = 1'b1;
      push_exp(k, a, w, d);
      @(posedge clk); #1;
      addr_v[k] = $urandom; wdata_v[k] = $urandom; we_v[k] = 1'($urandom_range(0, 1));
      lat = 1;
      while (!rdy_v[k] && lat <= 40) begin
         @(posedge clk); #1;
         lat++;
      end
      tests_run++;
      if (!rdy_v[k]) begin
         tests_failed++;
         $display("FAIL rdy_timeout k=%0d addr=%h got=no_rdy exp=rdy", k, a);
         void'(exp_q.pop_back());
      end else if (lat != ws_of(k) + 1) begin
         tests_failed++;
         $display("FAIL latency k=%0d addr=%h got=%0d exp=%0d", k, a, lat, ws_of(k) + 1);
      end
      if (!keep) ce_v[k] = 1'b0;
      @(posedge clk); #1;
   endtask

   // Write that is abandoned one cycle after capture: no rdy may follow.
   task automatic abort_req(input int k, input logic [31:0] a, input logic [31:0] d);
      addr_v[k] = a; wdata_v[k] = d; we_v[k] = 1'b1; ce_v[k] = 1'b1;
      @(posedge clk); #1;
      ce_v[k] = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         tests_run++;
         if (rdy_v[k]) begin
            tests_failed++;
            $display("FAIL abort_rdy k=%0d got=1 exp=0", k);
         end
      end
   endtask

   // Asynchronous reset asserted mid-cycle while a write sits in its rdy cycle.
   task automatic reset_during_write(input logic [31:0] a, input logic [31:0] d);
      int lat;
      addr_v[0] = a; wdata_v[0] = d; we_v[0] = 1'b1; ce_v[0] = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!rdy_v[0] && lat <= 40) begin
         @(posedge clk); #1;
         lat++;
      end
      tests_run++;
      if (lat != 3) begin
         tests_failed++;
         $display("FAIL reset_setup_latency got=%0d exp=3", lat);
      end
      rst = 1'b0; ce_v[0] = 1'b0;
      #1;
      tests_run += 3;
      if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy got=%b exp=0", rdy0); end
      if (err0 !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", err0); end
      if (rdata0 !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=0", rdata0); end
      #4;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
      @(posedge clk); #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            if (rdy_v[k]) begin
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL unexpected_rdy k=%0d got=rdy exp=none rdata=%h", k, rdata_of(k));
               end else begin
                  mon_e = exp_q.pop_front();
                  tests_run += 3;
                  if (mon_e[34:33] != 2'(k)) begin
                     tests_failed++;
                     $display("FAIL resp_source got=%0d exp=%0d", k, mon_e[34:33]);
                  end
                  if (err_v[k] !== mon_e[32]) begin
                     tests_failed++;
                     $display("FAIL resp_err k=%0d got=%b exp=%b", k, err_v[k], mon_e[32]);
                  end
                  if (rdata_of(k) !== mon_e[31:0]) begin
                     tests_failed++;
                     $display("FAIL resp_rdata k=%0d got=%h exp=%h", k, rdata_of(k), mon_e[31:0]);
                  end
               end
            end else if (err_v[k]) begin
               tests_run++;
               tests_failed++;
               $display("FAIL err_without_rdy k=%0d got=1 exp=0", k);
            end
         end
      end
   end

   // stimulus
   initial begin
      int          r;
      int          k;
      logic [31:0] a;

      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         addr_v[i] = 32'd0; wdata_v[i] = 32'd0; last_rd[i] = 32'd0;
      end
      we_v = 3'b000; ce_v = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      tests_run += 9;
      if (rdy_v !== 3'b000) begin tests_failed++; $display("FAIL reset_rdy_all got=%b exp=000", rdy_v); end
      if (err_v !== 3'b000) begin tests_failed++; $display("FAIL reset_err_all got=%b exp=000", err_v); end
      if (rdata0 !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
      if (rdata1 !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
      if (rdata2 !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
      if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy0 got=%b exp=0", rdy0); end
      if (rdy1 !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy1 got=%b exp=0", rdy1); end
      if (rdy2 !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy2 got=%b exp=0", rdy2); end
      if (err0 !== 1'b0) begin tests_failed++; $display("FAIL reset_err0 got=%b exp=0", err0); end
      rst = 1'b1;
      @(posedge clk); #1;

      // fill every word of every window so all later reads are defined
      for (int kk = 0; kk < 3; kk++)
         for (int i = 0; i < words_of(kk); i++)
            req(kk, 32'(base_of(kk) + 4 * i), 1'b1, $urandom, 1'b0);

      // write then read, two wait states
      req(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
      req(0, 32'h10, 1'b0, 32'd0, 1'b0);

      // zero wait states, ce held across back-to-back reads
      req(1, 32'h100, 1'b1, 32'd1, 1'b0);
      req(1, 32'h104, 1'b1, 32'd2, 1'b0);
      req(1, 32'h108, 1'b1, 32'd3, 1'b0);
      req(1, 32'h100, 1'b0, 32'd0, 1'b1);
      req(1, 32'h104, 1'b0, 32'd0, 1'b1);
      req(1, 32'h108, 1'b0, 32'd0, 1'b0);

      // misaligned and out-of-window accesses
      req(0, 32'h6,   1'b0, 32'd0,  1'b0);
      req(0, 32'h100, 1'b1, 32'h55, 1'b0);
      req(0, 32'h0,   1'b0, 32'd0,  1'b0);
      req(1, 32'hFC,  1'b0, 32'd0,  1'b0);
      req(2, 32'h240, 1'b1, 32'h66, 1'b0);
      req(2, 32'h200, 1'b0, 32'd0,  1'b0);
      req(2, 32'h23C, 1'b0, 32'd0,  1'b0);

      // aborted writes leave memory untouched
      abort_req(0, 32'h20, 32'h1234);
      req(0, 32'h20, 1'b0, 32'd0, 1'b0);
      abort_req(2, 32'h204, 32'h77);
      req(2, 32'h204, 1'b0, 32'd0, 1'b0);

      // read something nonzero first so the reset visibly clears rdata
      req(0, 32'h10, 1'b0, 32'd0, 1'b0);
      reset_during_write(32'h50, 32'hBAD0_0000);
      req(0, 32'h50, 1'b0, 32'd0, 1'b0);

      // randomized traffic
      repeat (300) begin
         k = $urandom_range(0, 2);
         r = $urandom_range(0, 9);
         if (r < 8)
            a = 32'(base_of(k) + 4 * $urandom_range(0, 32'(words_of(k) - 1)));
         else if (r == 8)
            a = 32'(base_of(k) + 4 * $urandom_range(0, 32'(words_of(k) - 1)) + $urandom_range(1, 3));
         else
            a = 32'(base_of(k) + 4 * words_of(k) + 4 * $urandom_range(0, 3));
         req(k, a, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      end

      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL pending_responses got=%0d exp=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/l2k_ram_resp.md
Name: l2k_ram_resp

Overview:
- Memory-side responder for the Limn2600 CPU external bus (addr/data/we/ce/rdy).
- Backs the bus with an on-chip word-addressed RAM and inserts a configurable number of wait states before signalling rdy.
- Used as boot/scratch RAM and as the bus-functional target for CPU and memory-scheduler simulation.
- Flags misaligned and out-of-window accesses with an error strobe.

Parameters:
- DEPTH_LOG2, 10: RAM depth is 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.
- WAIT_STATES, 2: idle cycles between request capture and rdy; 0..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from initiator.
- wdata  in  32  write data; connects to the CPU data_out.
- rdata  out  32  read data; connects to the CPU data_in.
- we  in  1  1 = write, 0 = read; sampled with the request.
- ce  in  1  request active.
- rdy  out  1  one-cycle completion strobe.
- err  out  1  one-cycle error strobe, coincident with rdy.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, counter 0, rdy=0, err=0, rdata=0. RAM contents are not cleared.
- A request in flight during reset is discarded; any pending write is not committed.
- States:
  - IDLE: on an edge with ce=1, capture addr, wdata and we into registers. Go to WAIT with cnt=WAIT_STATES, or straight to RESP if WAIT_STATES=0. With ce=0, stay in IDLE.
  - WAIT: decrement cnt each edge; go to RESP when cnt reaches 1. If ce is sampled 0 in WAIT, abort to IDLE: no rdy, no write.
  - RESP: rdy=1 for exactly this cycle, then IDLE unconditionally.
- Latency: rdy is high in the cycle following edge E0+WAIT_STATES, where E0 is the edge that sampled ce=1 in IDLE. Read latency is therefore WAIT_STATES+1 cycles.
- Write commit: the RAM write occurs at the RESP→IDLE edge, only when err is 0.
- Read data: rdata holds RAM[index] during the RESP cycle and keeps that value afterwards until the next read response. Writes do not update rdata.
- Address decode:
  - index = (addr_q - BASE_ADDR)[DEPTH_LOG2+1:2].
  - err=1 in the RESP cycle if addr_q[1:0]≠0, addr_q<BASE_ADDR, or addr_q≥BASE_ADDR+4*2^DEPTH_LOG2.
  - On err: a read returns rdata=0 and a write is dropped. rdy still pulses, so the initiator never hangs.
- Back-to-back: if ce is still 1 in the IDLE cycle after RESP, that is a new request. The initiator must drop ce in the cycle after rdy if it has nothing further.
- Inputs change while captured: addr, wdata and we changes after capture are ignored.
- WAIT_STATES=1: IDLE→WAIT(cnt=1)→RESP.

Test Plan:
- Write then read, WAIT_STATES=2: write 0xDEADBEEF to 0x10; rdy occurs 3 cycles after capture, err=0. Read 0x10 → rdy after 3 cycles, rdata=0xDEADBEEF.
- WAIT_STATES=0, back-to-back: hold ce=1 over reads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3) → rdy every second cycle, rdata=1, 2, 3.
- Misaligned / out of range: read 0x6 → rdy+err, rdata=0. Write 0x55 to BASE+4*2^DEPTH_LOG2 → rdy+err; a later read of 0x0 is unchanged.
- Abort: write 0x1234 to 0x20, drop ce one cycle after capture → no rdy. Read 0x20 returns the old value.
- Async reset mid-WAIT: rst low for half a cycle during a write → rdy=0 and err=0 immediately, write not committed. A post-reset ce is accepted normally.
- Address change after capture: change addr from 0x30 to 0x40 during WAIT → the response is for 0x30.
